// File: rtl/pwm_deadtime_driver.sv
// Complementary high/low gate driver with programmable dead time behind a registered PWM input.
// Optional fault latch is built only when PWM_FAULT_LATCH_EN is defined.
`timescale 1ns/1ps

module pwm_deadtime_driver #(
    parameter int unsigned DEAD_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in,
    input  logic              io_en,
    input  logic [DEAD_W-1:0] io_dead_cycles,
    input  logic              io_fault,
    output logic              io_hi,
    output logic              io_lo,
    output logic              io_dead,
    output logic              io_faulted
);

`ifdef PWM_FAULT_LATCH_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEAD_H = 3'd1,
        S_HI_ON  = 3'd2,
        S_DEAD_L = 3'd3,
        S_LO_ON  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEAD_H = 3'd1,
        S_HI_ON  = 3'd2,
        S_DEAD_L = 3'd3,
        S_LO_ON  = 3'd4
    } state_t;
`endif

    state_t             r_state;
    state_t             w_nxt;
    logic [DEAD_W-1:0]  r_cnt;
    logic [DEAD_W-1:0]  w_cnt_nxt;
    logic [DEAD_W-1:0]  w_deff_m1;
    logic               r_in_q;
    logic               r_run;
    logic               r_hi;
    logic               r_lo;
    logic               r_dead;

    // Zero dead time is treated as one cycle so the gates never switch back-to-back.
    assign w_deff_m1 = (io_dead_cycles == '0) ? '0 : (io_dead_cycles - DEAD_W'(1));

    // Next-state and dead counter; a mismatching input inside a dead interval reloads toward the new side.
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        if (!io_en || !r_run) begin
            w_nxt = S_IDLE;
        end
`ifdef PWM_FAULT_LATCH_EN
        else if (io_fault && (r_state != S_IDLE)) begin
            w_nxt = S_FAULT;
        end
`endif
        else begin
            case (r_state)
                S_IDLE: begin
                    w_nxt     = r_in_q ? S_DEAD_H : S_DEAD_L;
                    w_cnt_nxt = w_deff_m1;
                end
                S_HI_ON: begin
                    if (!r_in_q) begin
                        w_nxt     = S_DEAD_L;
                        w_cnt_nxt = w_deff_m1;
                    end
                end
                S_LO_ON: begin
                    if (r_in_q) begin
                        w_nxt     = S_DEAD_H;
                        w_cnt_nxt = w_deff_m1;
                    end
                end
                S_DEAD_H: begin
                    if (!r_in_q) begin
                        w_nxt     = S_DEAD_L;
                        w_cnt_nxt = w_deff_m1;
                    end else if (r_cnt == '0) begin
                        w_nxt = S_HI_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - DEAD_W'(1);
                    end
                end
                S_DEAD_L: begin
                    if (r_in_q) begin
                        w_nxt     = S_DEAD_H;
                        w_cnt_nxt = w_deff_m1;
                    end else if (r_cnt == '0) begin
                        w_nxt = S_LO_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - DEAD_W'(1);
                    end
                end
`ifdef PWM_FAULT_LATCH_EN
                S_FAULT: w_nxt = S_FAULT;
`endif
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    // r_run holds the FSM in IDLE for the first edge after reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_in_q  <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
            r_dead  <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_in_q  <= io_in;
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= (w_nxt == S_HI_ON);
            r_lo    <= (w_nxt == S_LO_ON);
            r_dead  <= (w_nxt == S_DEAD_H) || (w_nxt == S_DEAD_L);
        end
    end

    assign io_hi   = r_hi;
    assign io_lo   = r_lo;
    assign io_dead = r_dead;

`ifdef PWM_FAULT_LATCH_EN
    logic r_faulted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_faulted <= 1'b0;
        end else begin
            r_faulted <= (w_nxt == S_FAULT);
        end
    end

    assign io_faulted = r_faulted;
`else
    logic w_unused_fault;

    assign w_unused_fault = io_fault;
    assign io_faulted     = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed bench for pwm_deadtime_driver: dead-time lengths, aborts, PWM train widths, enable/reset and fault.
`timescale 1ns/1ps

module tb_pwm_deadtime_driver;

    localparam int W_HI_FALL = 0;
    localparam int W_HI_RISE = 1;
    localparam int W_LO_RISE = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_in = 1'b1;
    logic       io_en = 1'b1;
    logic       io_fault = 1'b0;
    logic [7:0] io_dead_cycles = 8'd4;
    logic       io_hi;
    logic       io_lo;
    logic       io_dead;
    logic       io_faulted;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_run  = 0;
    int lo_run  = 0;
    int hi_w[$];
    int lo_w[$];

    always #5 clock = ~clock;

    pwm_deadtime_driver #(.DEAD_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in          (io_in),
        .io_en          (io_en),
        .io_dead_cycles (io_dead_cycles),
        .io_fault       (io_fault),
        .io_hi          (io_hi),
        .io_lo          (io_lo),
        .io_dead        (io_dead),
        .io_faulted     (io_faulted)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Tick until the selected gate event, counting edges, dead cycles and high-side cycles.
    task automatic measure(input int which, input int budget,
                           output int n_edges, output int n_dead, output int n_hi);
        bit done;
        done    = 1'b0;
        n_edges = 0;
        n_dead  = 0;
        n_hi    = 0;
        while (!done && (n_edges < budget)) begin
            tick;
            n_edges++;
            if (io_dead) n_dead++;
            if (io_hi) n_hi++;
            case (which)
                W_HI_FALL: done = !io_hi;
                W_HI_RISE: done = io_hi;
                default:   done = io_lo;
            endcase
        end
        check("measure_done", int'(done), 1);
    endtask

    task automatic tick_pwm;
        tick;
        if (io_hi) hi_run++;
        else if (hi_run > 0) begin
            hi_w.push_back(hi_run);
            hi_run = 0;
        end
        if (io_lo) lo_run++;
        else if (lo_run > 0) begin
            lo_w.push_back(lo_run);
            lo_run = 0;
        end
    endtask

    always @(negedge clock) begin
        if (!reset) check("no_overlap", int'(io_hi & io_lo), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ne, nd, nh, d_first, h4;
        int seg_w[8];
        int exp_hi[4];
        int exp_lo[4];
        seg_w  = '{10, 7, 5, 12, 4, 9, 6, 8};
        exp_hi = '{7, 2, 1, 3};
        exp_lo = '{0, 4, 9, 6};

        // Reset held two cycles with enable and input high
        tick;
        tick;
        check("rst_hi", int'(io_hi), 0);
        check("rst_lo", int'(io_lo), 0);
        check("rst_dead", int'(io_dead), 0);
        check("rst_faulted", int'(io_faulted), 0);
        reset = 1'b0;
        measure(W_HI_RISE, 20, ne, nd, nh);
        check("t1_dead_cycles", nd, 4);
        check("t1_hi", int'(io_hi), 1);
        check("t1_lo", int'(io_lo), 0);

        // HI_ON -> LO_ON with D=4
        io_in = 1'b0;
        measure(W_HI_FALL, 10, ne, nd, nh);
        check("t2_hi_fall_edges", ne, 2);
        d_first = nd;
        measure(W_LO_RISE, 20, ne, nd, nh);
        check("t2_lo_rise_edges", ne, 4);
        check("t2_dead_cycles", nd + d_first, 4);

        // D=0 behaves as one cycle
        io_dead_cycles = 8'd0;
        io_in = 1'b1;
        measure(W_HI_RISE, 10, ne, nd, nh);
        check("t3a_dead_cycles", nd, 1);
        check("t3a_edges", ne, 3);

        // D=255, with a mid-interval change of io_dead_cycles that must be ignored
        io_dead_cycles = 8'd255;
        io_in = 1'b0;
        tick;
        tick;
        check("t3b_dead_entry", int'(io_dead), 1);
        io_dead_cycles = 8'd2;
        measure(W_LO_RISE, 300, ne, nd, nh);
        check("t3b_dead_cycles", nd + 1, 255);
        check("t3b_edges", ne, 255);

        // Short high pulse while in LO_ON never reaches the high side
        io_dead_cycles = 8'd8;
        io_in = 1'b1;
        tick;
        tick;
        check("t4_lo_dropped", int'(io_lo), 0);
        h4 = int'(io_hi);
        tick;
        h4 += int'(io_hi);
        io_in = 1'b0;
        measure(W_LO_RISE, 30, ne, nd, nh);
        check("t4_hi_seen", nh + h4, 0);
        check("t4_edges", ne, 10);
        check("t4_dead_cycles", nd, 9);

        // PWM train with D=3: gate widths are input widths minus 3
        io_dead_cycles = 8'd3;
        hi_run = 0;
        lo_run = 0;
        for (int s = 0; s < 8; s++) begin
            io_in = ((s % 2) == 0);
            for (int c = 0; c < seg_w[s]; c++) tick_pwm;
        end
        check("t5_hi_count", hi_w.size(), 4);
        check("t5_lo_count", lo_w.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t5_hi_width", (i < hi_w.size()) ? hi_w[i] : -1, exp_hi[i]);
        end
        for (int i = 1; i < 4; i++) begin
            check("t5_lo_width", (i < lo_w.size()) ? lo_w[i] : -1, exp_lo[i]);
        end

        io_in = 1'b1;
        measure(W_HI_RISE, 10, ne, nd, nh);
        check("t6_pre_hi", int'(io_hi), 1);
`ifdef PWM_FAULT_LATCH_EN
        // Fault latch: held through input toggling, cleared only by dropping enable
        io_fault = 1'b1;
        tick;
        io_fault = 1'b0;
        check("t6_hi_fault", int'(io_hi), 0);
        check("t6_faulted", int'(io_faulted), 1);
        for (int i = 0; i < 6; i++) begin
            io_in = ~io_in;
            tick;
            check("t6_gates_held", int'(io_hi | io_lo), 0);
            check("t6_faulted_held", int'(io_faulted), 1);
        end
        io_in = 1'b1;
        io_en = 1'b0;
        tick;
        check("t6_fault_cleared", int'(io_faulted), 0);
        io_en = 1'b1;
        measure(W_HI_RISE, 10, ne, nd, nh);
        check("t6_reen_edges", ne, 4);
        check("t6_reen_dead", nd, 3);
`else
        // Without the latch, io_fault has no effect
        io_fault = 1'b1;
        tick;
        tick;
        io_fault = 1'b0;
        check("t6_faulted_tied", int'(io_faulted), 0);
        check("t6_hi_kept", int'(io_hi), 1);
`endif

        // Enable drop forces both low; re-enable goes through a dead interval
        io_en = 1'b0;
        tick;
        check("t7_en_hi", int'(io_hi), 0);
        check("t7_en_lo", int'(io_lo), 0);
        check("t7_en_dead", int'(io_dead), 0);
        io_en = 1'b1;
        measure(W_HI_RISE, 10, ne, nd, nh);
        check("t7_reen_edges", ne, 4);
        check("t7_reen_dead", nd, 3);

        // Asynchronous reset mid-operation drops the gate immediately
        #2;
        reset = 1'b1;
        #1;
        check("t8_async_hi", int'(io_hi), 0);
        tick;
        reset = 1'b0;
        measure(W_HI_RISE, 20, ne, nd, nh);
        check("t8_restart_edges", ne, 5);
        check("t8_restart_dead", nd, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
